// File: rtl/result_matrix_serializer.sv
// result_matrix_serializer: captures a 2x2 result matrix per handshake and streams it row-major over valid/ready.
// Define SER_CHECKSUM_EN to append a 5th beat carrying r11^r12^r21^r22.
module result_matrix_serializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r11,
  input  logic [WIDTH-1:0] r12,
  input  logic [WIDTH-1:0] r21,
  input  logic [WIDTH-1:0] r22,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] frames_done
);
`ifdef SER_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] m11, m12, m21, m22;
  logic beat, done, cap;
  always_comb begin
    out_valid = state == SEND;
    out_last  = out_valid && out_idx == LAST_IDX;
    beat      = out_valid && out_ready;
    done      = beat && out_last;
    in_ready  = state == IDLE || done;
    cap       = in_valid && in_ready;
    state_nx  = cap ? SEND : done ? IDLE : state;
    out_data  = !out_valid     ? '0  :
                out_idx == 3'd0 ? m11 :
                out_idx == 3'd1 ? m12 :
                out_idx == 3'd2 ? m21 :
                out_idx == 3'd3 ? m22 : m11 ^ m12 ^ m21 ^ m22;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m11 <= '0;
      m12 <= '0;
      m21 <= '0;
      m22 <= '0;
      out_idx <= '0;
      frames_done <= '0;
    end else begin
      if (cap) begin
        m11 <= r11;
        m12 <= r12;
        m21 <= r21;
        m22 <= r22;
      end
      // a capture coinciding with the last beat restarts at idx 0 with no bubble
      if (cap || done) out_idx <= '0;
      else if (beat) out_idx <= out_idx + 3'd1;
      if (done) frames_done <= frames_done + CNT_W'(1);
    end
endmodule
